nw_traceback: RTL and testbench
===============================

// Module: nw_traceback
// PURPOSE
//  Traceback engine for the Needleman-Wunsch scorer. It reads a completed LENGTH x LENGTH score matrix through
//  a synchronous read port and walks it from (LENGTH-1,LENGTH-1) back to the origin. It emits the alignment as a
//  valid/ready stream of edit ops, last op first, for downstream alignment formatting.
// PARAMETERS
//  LENGTH    10  chars per string; matrix is LENGTH x LENGTH
//  CWIDTH    2   bits per character
//  SWIDTH    16  bits per signed score
//  MATCH     1   diagonal weight when chars equal (signed)
//  INDEL     -1  gap weight (signed)
//  MISMATCH  -1  diagonal weight when chars differ (signed)
//  AW        $clog2(LENGTH)  matrix index width (derived, localparam)
// PORTS
//  clk       in   1               clock
//  rst       in   1               synchronous, active-high reset
//  start     in   1               begin traceback; ignored while busy
//  s1        in   LENGTH*CWIDTH   row string, char i at [i*CWIDTH +: CWIDTH]; latched on accepted start
//  s2        in   LENGTH*CWIDTH   column string, same packing; latched on accepted start
//  busy      out  1               high from accepted start until done
//  rd_en     out  1               matrix read strobe
//  rd_row    out  AW              row i of read
//  rd_col    out  AW              column j of read
//  rd_data   in   SWIDTH signed   H[rd_row][rd_col], valid exactly 1 cycle after rd_en
//  op_valid  out  1               op stream valid
//  op_ready  in   1               op stream ready
//  op        out  2               00 MATCH, 01 MISMATCH (diagonal), 10 UP (s1 char vs gap), 11 LEFT (gap vs s2 char)
//  op_a      out  CWIDTH          s1[i] for diag/UP, else 0
//  op_b      out  CWIDTH          s2[j] for diag/LEFT, else 0
//  op_last   out  1               marks final op (reaches origin)
//  done      out  1               one-cycle pulse at end of traceback (normal or error)
//  err       out  1               matrix inconsistent; sticky until next accepted start
// BEHAVIOUR
//  - Reset: busy, rd_en, op_valid, op_last, done, err = 0; op, op_a, op_b, rd_row, rd_col = 0; FSM -> IDLE.
//  - Virtual boundary, never read: H[-1][-1]=0, H[-1][j]=(j+1)*INDEL, H[i][-1]=(i+1)*INDEL.
//  - Signed internal indices are AW+1 bits. Score math is SWIDTH signed with no saturation.
//  - FSM: IDLE -> LOAD (read H[L-1][L-1], cur <- rd_data) -> CHK_DIAG -> CHK_UP -> CHK_LEFT -> EMIT -> CHK_DIAG | DONE.
//  - Each CHK state fetches its neighbour: 1 read and 1 wait cycle, or 0 cycles if the neighbour is virtual.
//    * CHK_DIAG: if cur == H[i-1][j-1] + (s1[i]==s2[j] ? MATCH : MISMATCH), emit diag op; i--, j--.
//    * else CHK_UP: if cur == H[i-1][j] + INDEL, emit UP; i--.
//    * else CHK_LEFT: if cur == H[i][j-1] + INDEL, emit LEFT; j--.
//    * else set err, pulse done, return to IDLE, and emit no further ops.
//  - Tie priority is fixed: diag > UP > LEFT.
//  - After each op, cur <- the neighbour score that matched. No re-read.
//  - Edge walk, no reads:
//    * i<0, j>=0: emit LEFT ops down to j=0.
//    * j<0, i>=0: emit UP ops down to i=0.
//  - Origin: the op that brings (i,j) to (-1,-1) carries op_last=1. DONE pulses done for 1 cycle, then IDLE.
//  - Op count is between LENGTH and 2*LENGTH.
//  - Stream rules:
//    * op_valid held with payload stable until op_ready.
//    * No reads issued while an op is pending.
//    * Transfer = op_valid & op_ready.
//  - start while busy is ignored. start in the same cycle as the done pulse is ignored.
//  - rst mid-operation: abort immediately, drop op_valid with no last, reset all outputs.
// TESTING
//  - Identity, LENGTH=2, s1=s2="AC" (A=0,C=1), H=[[1,0],[0,2]], op_ready=1:
//    -> MATCH(C,C), MATCH(A,A)+last; done; err=0.
//  - Gaps, LENGTH=2, s1="AG", s2="GA" (G=2), H=[[-1,0],[0,-1]]:
//    -> UP(a=G), MATCH(A,A), LEFT(b=G)+last; 3 ops.
//  - Backpressure on the gaps case: op_ready=0 for 5 cycles at each op.
//    -> op_valid and payload stable; rd_en=0 while stalled; same op sequence.
//  - Corrupt matrix, identity strings, H[1][1]=7:
//    -> no ops; err=1; done pulses; busy=0 next cycle.
//  - rst asserted 3 cycles after start on a LENGTH=10 random case:
//    -> all outputs 0 next cycle; a following start completes and matches the software golden traceback.
//  - Random LENGTH=10, 200 seeds, random op_ready: op stream equals the golden model. A start during busy has no effect.

Source files
------------

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks a finished score matrix from the far corner to the origin
// and streams the edit ops (last op first) over a valid/ready handshake.
module nw_traceback #(
  parameter int LENGTH   = 10,
  parameter int CWIDTH   = 2,
  parameter int SWIDTH   = 16,
  parameter int MATCH    = 1,
  parameter int INDEL    = -1,
  parameter int MISMATCH = -1,
  localparam int AW      = $clog2(LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  output logic                     busy,
  output logic                     rd_en,
  output logic [AW-1:0]            rd_row,
  output logic [AW-1:0]            rd_col,
  input  logic signed [SWIDTH-1:0] rd_data,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [1:0]               op,
  output logic [CWIDTH-1:0]        op_a,
  output logic [CWIDTH-1:0]        op_b,
  output logic                     op_last,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHK_DIAG, S_CHK_UP, S_CHK_LEFT, S_EMIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_MATCH = 2'b00, OP_MISMATCH = 2'b01, OP_UP = 2'b10, OP_LEFT = 2'b11
  } op_t;

  localparam logic signed [SWIDTH-1:0] W_MATCH    = SWIDTH'(MATCH);
  localparam logic signed [SWIDTH-1:0] W_MISMATCH = SWIDTH'(MISMATCH);
  localparam logic signed [SWIDTH-1:0] W_INDEL    = SWIDTH'(INDEL);
  localparam logic signed [AW:0]       IDX_ONE    = (AW+1)'(1);
  localparam logic signed [AW:0]       IDX_LAST   = (AW+1)'(LENGTH-1);

  state_t                    state;
  logic [1:0]                rphase;   // 0: issue read, 1: wait, 2: rd_data valid
  logic signed [AW:0]        i, j;
  logic signed [SWIDTH-1:0]  cur;
  logic [CWIDTH-1:0]         a_q [LENGTH];
  logic [CWIDTH-1:0]         b_q [LENGTH];

  logic signed [AW:0]        ni, nj, i_nxt, j_nxt;
  logic                      nb_virt, need_read, take, chars_eq;
  logic signed [SWIDTH-1:0]  nb_score, diag_w;
  logic [CWIDTH-1:0]         ch_a, ch_b;
  op_t                       nop;

  // Score of a cell outside the matrix; only called with at least one negative index.
  function automatic logic signed [SWIDTH-1:0] edge_score(input logic signed [AW:0] r,
                                                          input logic signed [AW:0] c);
    logic signed [SWIDTH-1:0] k;
    k = r[AW] ? SWIDTH'(c) : SWIDTH'(r);
    if (r[AW] && c[AW]) return '0;
    return (k + SWIDTH'(1)) * W_INDEL;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    ni    = i;
    nj    = j;
    take  = 1'b0;
    nop   = OP_MATCH;
    i_nxt = i;
    j_nxt = j;
    case (state)
      S_LOAD:     begin ni = IDX_LAST;    nj = IDX_LAST;    end
      S_CHK_DIAG: begin ni = i - IDX_ONE; nj = j - IDX_ONE; end
      S_CHK_UP:   ni = i - IDX_ONE;
      S_CHK_LEFT: nj = j - IDX_ONE;
      default:    ;
    endcase

    nb_virt   = ni[AW] | nj[AW];
    nb_score  = nb_virt ? edge_score(ni, nj) : rd_data;
    need_read = (state inside {S_LOAD, S_CHK_DIAG, S_CHK_UP, S_CHK_LEFT}) &&
                !nb_virt && (rphase != 2'd2);

    ch_a     = a_q[i[AW-1:0]];
    ch_b     = b_q[j[AW-1:0]];
    chars_eq = (ch_a == ch_b);
    diag_w   = chars_eq ? W_MATCH : W_MISMATCH;

    // Tie priority diag > UP > LEFT falls out of the CHK state order.
    case (state)
      S_CHK_DIAG: begin
        if (i[AW]) begin
          take = 1'b1; nop = OP_LEFT; j_nxt = nj;
        end else if (j[AW]) begin
          take = 1'b1; nop = OP_UP; i_nxt = ni;
        end else if (cur == nb_score + diag_w) begin
          take  = 1'b1;
          nop   = chars_eq ? OP_MATCH : OP_MISMATCH;
          i_nxt = ni;
          j_nxt = nj;
        end
      end
      S_CHK_UP: if (cur == nb_score + W_INDEL) begin
        take = 1'b1; nop = OP_UP; i_nxt = ni;
      end
      S_CHK_LEFT: if (cur == nb_score + W_INDEL) begin
        take = 1'b1; nop = OP_LEFT; j_nxt = nj;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the latched strings are deliberately left out of reset; they are always rewritten before use.
      state    <= S_IDLE;
      rphase   <= 2'd0;
      i        <= '0;
      j        <= '0;
      cur      <= '0;
      busy     <= 1'b0;
      rd_en    <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
      op_valid <= 1'b0;
      op       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (need_read) begin
      if (rphase == 2'd0) begin
        rd_en  <= 1'b1;
        rd_row <= ni[AW-1:0];
        rd_col <= nj[AW-1:0];
        rphase <= 2'd1;
      end else begin
        rd_en  <= 1'b0;
        rphase <= 2'd2;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            busy  <= 1'b1;
            err   <= 1'b0;
            i     <= IDX_LAST;
            j     <= IDX_LAST;
            for (int k = 0; k < LENGTH; k++) begin
              a_q[k] <= s1[k*CWIDTH +: CWIDTH];
              b_q[k] <= s2[k*CWIDTH +: CWIDTH];
            end
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          cur    <= nb_score;
          rphase <= 2'd0;
          state  <= S_CHK_DIAG;
        end
        S_CHK_DIAG, S_CHK_UP, S_CHK_LEFT: begin
          rphase <= 2'd0;
          if (take) begin
            op_valid <= 1'b1;
            op       <= nop;
            op_a     <= (nop != OP_LEFT) ? ch_a : '0;
            op_b     <= (nop != OP_UP)   ? ch_b : '0;
            op_last  <= (&i_nxt) & (&j_nxt);
            cur      <= nb_score;
            i        <= i_nxt;
            j        <= j_nxt;
            state    <= S_EMIT;
          end else if (state == S_CHK_DIAG) begin
            state <= S_CHK_UP;
          end else if (state == S_CHK_UP) begin
            state <= S_CHK_LEFT;
          end else begin
            err   <= 1'b1;
            state <= S_DONE;
          end
        end
        S_EMIT: if (op_ready) begin
          op_valid <= 1'b0;
          op_last  <= 1'b0;
          state    <= op_last ? S_DONE : S_CHK_DIAG;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nw_traceback.sv
// Directed and random bench for nw_traceback: a LENGTH=2 instance for the hand-built matrices and a
// LENGTH=10 instance checked against a software fill + traceback through per-instance op scoreboards.
module tb_nw_traceback;

  localparam int T_MATCH = 1;
  localparam int T_INDEL = -1;
  localparam int T_MISM  = -1;
  localparam logic [1:0] K_MATCH = 2'b00, K_MISM = 2'b01, K_UP = 2'b10, K_LEFT = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic              start2, busy2, rd_en2, op_valid2, op_ready2, op_last2, done2, err2;
  logic [3:0]        s1_2, s2_2;
  logic [0:0]        rd_row2, rd_col2;
  logic signed [15:0] rd_data2;
  logic [1:0]        op2, op_a2, op_b2;

  logic              start10, busy10, rd_en10, op_valid10, op_ready10, op_last10, done10, err10;
  logic [19:0]       s1_10, s2_10;
  logic [3:0]        rd_row10, rd_col10;
  logic signed [15:0] rd_data10;
  logic [1:0]        op10, op_a10, op_b10;

  int         mem2  [2][2];
  int         mem10 [10][10];
  logic [1:0] c1 [10];
  logic [1:0] c2 [10];
  logic [6:0] q2  [$];
  logic [6:0] q10 [$];
  int n_assert = 0;
  int n_fail   = 0;

  nw_traceback #(.LENGTH(2), .CWIDTH(2), .SWIDTH(16), .MATCH(1), .INDEL(-1), .MISMATCH(-1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .s1(s1_2), .s2(s2_2), .busy(busy2),
    .rd_en(rd_en2), .rd_row(rd_row2), .rd_col(rd_col2), .rd_data(rd_data2),
    .op_valid(op_valid2), .op_ready(op_ready2), .op(op2), .op_a(op_a2), .op_b(op_b2),
    .op_last(op_last2), .done(done2), .err(err2)
  );

  nw_traceback #(.LENGTH(10), .CWIDTH(2), .SWIDTH(16), .MATCH(1), .INDEL(-1), .MISMATCH(-1)) u_dut10 (
    .clk(clk), .rst(rst), .start(start10), .s1(s1_10), .s2(s2_10), .busy(busy10),
    .rd_en(rd_en10), .rd_row(rd_row10), .rd_col(rd_col10), .rd_data(rd_data10),
    .op_valid(op_valid10), .op_ready(op_ready10), .op(op10), .op_a(op_a10), .op_b(op_b10),
    .op_last(op_last10), .done(done10), .err(err10)
  );

  // Synchronous read ports: data one cycle after the strobe.
  always @(posedge clk) if (rd_en2)  rd_data2  <= 16'(mem2[rd_row2][rd_col2]);
  always @(posedge clk) if (rd_en10) rd_data10 <= 16'(mem10[rd_row10][rd_col10]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: pop on every transfer seen half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (!rst && op_valid2 && op_ready2) begin
      n_assert++;
      assert (q2.size() != 0) else begin
        n_fail++;
        $error("FAIL op2_extra: observed op %0h with nothing expected", op2);
      end
      if (q2.size() != 0) check("op2", 32'({op2, op_a2, op_b2, op_last2}), 32'(q2.pop_front()));
    end
    if (!rst && op_valid10 && op_ready10) begin
      n_assert++;
      assert (q10.size() != 0) else begin
        n_fail++;
        $error("FAIL op10_extra: observed op %0h with nothing expected", op10);
      end
      if (q10.size() != 0) check("op10", 32'({op10, op_a10, op_b10, op_last10}), 32'(q10.pop_front()));
    end
  end

  function automatic int hv(int r, int c);
    if (r < 0 && c < 0) return 0;
    if (r < 0) return (c + 1) * T_INDEL;
    if (c < 0) return (r + 1) * T_INDEL;
    return mem10[r][c];
  endfunction

  task automatic gen10();
    for (int k = 0; k < 10; k++) begin
      c1[k] = 2'($urandom_range(0, 3));
      c2[k] = 2'($urandom_range(0, 3));
      s1_10[k*2 +: 2] = c1[k];
      s2_10[k*2 +: 2] = c2[k];
    end
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        int d, u, l, m;
        d = hv(r-1, c-1) + ((c1[r] == c2[c]) ? T_MATCH : T_MISM);
        u = hv(r-1, c) + T_INDEL;
        l = hv(r, c-1) + T_INDEL;
        m = (d > u) ? d : u;
        mem10[r][c] = (m > l) ? m : l;
      end
    end
  endtask

  // Software golden traceback of the current LENGTH=10 case.
  task automatic golden10();
    int i = 9;
    int j = 9;
    int cur = mem10[9][9];
    int nb;
    logic [1:0] o, a, b;
    while (i >= 0 || j >= 0) begin
      a = 2'd0;
      b = 2'd0;
      if (i < 0) begin
        o = K_LEFT; b = c2[j]; j--;
      end else if (j < 0) begin
        o = K_UP; a = c1[i]; i--;
      end else begin
        nb = hv(i-1, j-1);
        if (cur == nb + ((c1[i] == c2[j]) ? T_MATCH : T_MISM)) begin
          o = (c1[i] == c2[j]) ? K_MATCH : K_MISM;
          a = c1[i]; b = c2[j]; i--; j--; cur = nb;
        end else if (cur == hv(i-1, j) + T_INDEL) begin
          o = K_UP; a = c1[i]; cur = hv(i-1, j); i--;
        end else begin
          o = K_LEFT; b = c2[j]; cur = hv(i, j-1); j--;
        end
      end
      q10.push_back({o, a, b, (i < 0 && j < 0)});
    end
  endtask

  task automatic run2(input string tag, input bit bp, input bit exp_err);
    bit seen = 1'b0;
    op_ready2 = !bp;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (bp && op_valid2) begin
        for (int k = 0; k < 5; k++) begin
          check({tag, "_hold"}, 32'({op_valid2, op2, op_a2, op_b2, op_last2}),
                32'({1'b1, (q2.size() != 0) ? q2[0] : 7'h0}));
          check({tag, "_no_read"}, 32'(rd_en2), 32'd0);
          tick();
        end
        op_ready2 = 1'b1;
        tick();
        op_ready2 = 1'b0;
      end else begin
        tick();
      end
      if (done2) seen = 1'b1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_err"}, 32'(err2), 32'(exp_err));
    check({tag, "_drained"}, 32'(q2.size()), 32'd0);
    tick();
    check({tag, "_idle"}, 32'(busy2), 32'd0);
    op_ready2 = 1'b1;
  endtask

  task automatic run10(input string tag, input bit rand_ready, input bit poke, input bit at_done);
    bit seen = 1'b0;
    logic [19:0] save;
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      op_ready10 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && cyc == 4) begin
        save = s1_10; s1_10 = ~s1_10; start10 = 1'b1;
      end
      if (poke && cyc == 5) begin
        s1_10 = save; start10 = 1'b0;
      end
      tick();
      if (done10) seen = 1'b1;
    end
    op_ready10 = 1'b1;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_err"}, 32'(err10), 32'd0);
    check({tag, "_drained"}, 32'(q10.size()), 32'd0);
    if (at_done && seen) begin
      start10 = 1'b1;
      tick();
      start10 = 1'b0;
      check({tag, "_start_at_done"}, 32'(busy10), 32'd0);
    end
    tick();
    check({tag, "_idle"}, 32'(busy10), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start2 = 1'b0; start10 = 1'b0;
    op_ready2 = 1'b1; op_ready10 = 1'b1;
    s1_2 = '0; s2_2 = '0; s1_10 = '0; s2_10 = '0;
    tick();
    tick();
    check("reset2", 32'({busy2, rd_en2, op_valid2, op_last2, done2, err2, op2, op_a2, op_b2,
                         rd_row2, rd_col2}), 32'd0);
    check("reset10", 32'({busy10, rd_en10, op_valid10, op_last10, done10, err10, op10, op_a10,
                          op_b10, rd_row10, rd_col10}), 32'd0);
    rst = 1'b0;
    tick();

    // Identity "AC" vs "AC" (A=0, C=1).
    s1_2 = {2'd1, 2'd0};
    s2_2 = {2'd1, 2'd0};
    mem2 = '{'{1, 0}, '{0, 2}};
    q2.push_back({K_MATCH, 2'd1, 2'd1, 1'b0});
    q2.push_back({K_MATCH, 2'd0, 2'd0, 1'b1});
    run2("identity", 1'b0, 1'b0);

    // Gaps "AG" vs "GA" (G=2), with and without backpressure.
    s1_2 = {2'd2, 2'd0};
    s2_2 = {2'd0, 2'd2};
    mem2 = '{'{-1, 0}, '{0, -1}};
    for (int pass = 0; pass < 2; pass++) begin
      q2.push_back({K_UP,    2'd2, 2'd0, 1'b0});
      q2.push_back({K_MATCH, 2'd0, 2'd0, 1'b0});
      q2.push_back({K_LEFT,  2'd0, 2'd2, 1'b1});
      run2((pass == 0) ? "gaps" : "gaps_bp", pass == 1, 1'b0);
    end

    // Corrupt corner cell: no predecessor matches.
    s1_2 = {2'd1, 2'd0};
    s2_2 = {2'd1, 2'd0};
    mem2 = '{'{1, 0}, '{0, 7}};
    run2("corrupt", 1'b0, 1'b1);
    check("corrupt_err_sticky", 32'(err2), 32'd1);

    // Reset three cycles into a LENGTH=10 traceback, then rerun the same case.
    gen10();
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_outputs", 32'({busy10, rd_en10, op_valid10, op_last10, done10, err10, op10,
                                 op_a10, op_b10, rd_row10, rd_col10}), 32'd0);
    rst = 1'b0;
    q10.delete();
    golden10();
    run10("after_rst", 1'b1, 1'b0, 1'b0);

    for (int s = 0; s < 200; s++) begin
      gen10();
      golden10();
      run10($sformatf("rand%0d", s), 1'b1, s == 7, s == 11);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
